// File: rtl/oob_controller_param_if.sv
// Bundle of transceiver-side, link-side and platform signals used by the OOB
// sequencer. The master modport is the sequencer; the slave modport is its
// environment (transceiver wrapper, link layer and platform logic).
interface oob_controller_param_if;
  logic        platform_ready;
  logic        platform_error;
  logic        linkup;
  logic        link_lost;
  logic        tx_comm_reset;
  logic        tx_comm_wake;
  logic        tx_oob_complete;
  logic        comm_init_detect;
  logic        comm_wake_detect;
  logic [31:0] rx_din;
  logic [3:0]  rx_is_k;
  logic        rx_is_elec_idle;
  logic        rx_byte_is_aligned;
  logic [31:0] tx_dout;
  logic        tx_is_k;
  logic        tx_set_elec_idle;
  logic [3:0]  retry_count;
  logic [3:0]  lax_state;

  modport master (
    input  platform_ready, tx_oob_complete, comm_init_detect, comm_wake_detect,
           rx_din, rx_is_k, rx_is_elec_idle, rx_byte_is_aligned,
    output platform_error, linkup, link_lost, tx_comm_reset, tx_comm_wake,
           tx_dout, tx_is_k, tx_set_elec_idle, retry_count, lax_state
  );

  modport slave (
    output platform_ready, tx_oob_complete, comm_init_detect, comm_wake_detect,
           rx_din, rx_is_k, rx_is_elec_idle, rx_byte_is_aligned,
    input  platform_error, linkup, link_lost, tx_comm_reset, tx_comm_wake,
           tx_dout, tx_is_k, tx_set_elec_idle, retry_count, lax_state
  );
endinterface

// File: rtl/oob_controller_param.sv
// SATA PHY OOB / link-initialisation sequencer with programmable timeouts,
// bounded COMRESET retries, optional SYNC wait and loss-of-signal detection.
// All outputs except lax_state are registered and derived from the next state.
module oob_controller_param #(
  parameter int RESET_TIMEOUT   = 162,
  parameter int INIT_TIMEOUT    = 32'h00040000,
  parameter int NO_INIT_TIMEOUT = 4096,
  parameter int WAKE_TIMEOUT    = 155,
  parameter int WAKE_RX_TIMEOUT = 132013,
  parameter int ALIGN_TIMEOUT   = 132013,
  parameter int MAX_RETRIES     = 4,
  parameter int ALIGN_RELEASE   = 4,
  parameter int REQUIRE_SYNC    = 0,
  parameter int SYNC_TIMEOUT    = 65536,
  parameter int IDLE_LOSS       = 64
) (
  input logic                   clk,
  input logic                   rst,
  oob_controller_param_if.master oob
);

  localparam logic [31:0] PRIM_ALIGN = 32'h7B4A4ABC;
  localparam logic [31:0] PRIM_SYNC  = 32'hB5B5957C;
  localparam logic [31:0] DIALTONE   = 32'h4A4A4A4A;

  typedef enum logic [3:0] {
    IDLE             = 4'h0,
    SEND_RESET       = 4'h1,
    WAIT_FOR_INIT    = 4'h2,
    WAIT_FOR_NO_INIT = 4'h3,
    SEND_WAKE        = 4'h4,
    WAIT_FOR_WAKE    = 4'h5,
    WAIT_FOR_NO_WAKE = 4'h6,
    WAIT_FOR_ALIGN   = 4'h7,
    SEND_ALIGN       = 4'h8,
    DETECT_SYNC      = 4'h9,
    READY            = 4'hA,
    ERROR            = 4'hB
  } state_t;

  state_t      state_r, next_s;
  logic [31:0] timer_r;
  logic [3:0]  retry_r;
  logic [7:0]  release_r;
  logic [15:0] idle_cnt_r;
  logic        linkup_r, link_lost_r, comm_reset_r, comm_wake_r, platform_error_r;
  logic [31:0] dout_r;
  logic        is_k_r, elec_idle_r;

  logic        timeout_s, align_det_s, sync_det_s, fail_s, retry_inc_s;
  logic        comm_reset_s, comm_wake_s, lost_s;
  logic [7:0]  release_inc_s;
  logic [15:0] idle_inc_s;
  logic [31:0] dout_nxt_s;
  logic        is_k_nxt_s, elec_idle_nxt_s;

  // Timeout reload value for the state being entered; 0 where no timeout applies.
  function automatic logic [31:0] timer_load(input state_t s);
    case (s)
      SEND_RESET:       timer_load = 32'(RESET_TIMEOUT);
      WAIT_FOR_INIT:    timer_load = 32'(INIT_TIMEOUT);
      WAIT_FOR_NO_INIT: timer_load = 32'(NO_INIT_TIMEOUT);
      SEND_WAKE:        timer_load = 32'(WAKE_TIMEOUT);
      WAIT_FOR_WAKE:    timer_load = 32'(WAKE_RX_TIMEOUT);
      WAIT_FOR_ALIGN:   timer_load = 32'(ALIGN_TIMEOUT);
      DETECT_SYNC:      timer_load = 32'(SYNC_TIMEOUT);
      default:          timer_load = 32'd0;
    endcase
  endfunction

  assign timeout_s     = (timer_r == 32'd0);
  assign align_det_s   = (|oob.rx_is_k) && (oob.rx_din == PRIM_ALIGN) && oob.rx_byte_is_aligned;
  assign sync_det_s    = (|oob.rx_is_k) && (oob.rx_din == PRIM_SYNC);
  assign release_inc_s = release_r + 8'd1;
  assign idle_inc_s    = idle_cnt_r + 16'd1;

  // State, timer, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r          <= IDLE;
      timer_r          <= 32'd0;
      retry_r          <= 4'd0;
      release_r        <= 8'd0;
      idle_cnt_r       <= 16'd0;
      linkup_r         <= 1'b0;
      link_lost_r      <= 1'b0;
      comm_reset_r     <= 1'b0;
      comm_wake_r      <= 1'b0;
      platform_error_r <= 1'b0;
      dout_r           <= 32'd0;
      is_k_r           <= 1'b0;
      elec_idle_r      <= 1'b1;
    end else begin
      state_r <= next_s;
      if (next_s != state_r) begin
        timer_r <= timer_load(next_s);
      end else if (!timeout_s) begin
        timer_r <= timer_r - 32'd1;
      end else begin
        timer_r <= 32'd0;
      end
      if (next_s == IDLE) begin
        retry_r <= 4'd0;
      end else if (retry_inc_s) begin
        retry_r <= retry_r + 4'd1;
      end else begin
        retry_r <= retry_r;
      end
      // Release counter is not cleared by a returning ALIGN.
      if (state_r == WAIT_FOR_ALIGN) begin
        release_r <= 8'd0;
      end else if (state_r == SEND_ALIGN && !align_det_s) begin
        release_r <= release_inc_s;
      end else begin
        release_r <= release_r;
      end
      if (state_r == READY && oob.rx_is_elec_idle) begin
        idle_cnt_r <= idle_inc_s;
      end else begin
        idle_cnt_r <= 16'd0;
      end
      linkup_r         <= (next_s == READY);
      link_lost_r      <= lost_s;
      comm_reset_r     <= comm_reset_s;
      comm_wake_r      <= comm_wake_s;
      platform_error_r <= (next_s == ERROR);
      dout_r           <= dout_nxt_s;
      is_k_r           <= is_k_nxt_s;
      elec_idle_r      <= elec_idle_nxt_s;
    end
  end

  // Next-state selection, strobe requests and retry/abort arbitration.
  always_comb begin
    next_s       = state_r;
    fail_s       = 1'b0;
    retry_inc_s  = 1'b0;
    comm_reset_s = 1'b0;
    comm_wake_s  = 1'b0;
    lost_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (oob.platform_ready) begin
          next_s       = SEND_RESET;
          comm_reset_s = 1'b1;
        end else begin
          next_s = IDLE;
        end
      end
      SEND_RESET: begin
        if (timeout_s || oob.tx_oob_complete) next_s = WAIT_FOR_INIT;
        else                                  next_s = state_r;
      end
      WAIT_FOR_INIT: begin
        if (oob.comm_init_detect) next_s = WAIT_FOR_NO_INIT;
        else if (timeout_s)       fail_s = 1'b1;
        else                      next_s = state_r;
      end
      WAIT_FOR_NO_INIT: begin
        if (!oob.comm_init_detect && (timeout_s || oob.tx_oob_complete)) begin
          next_s      = SEND_WAKE;
          comm_wake_s = 1'b1;
        end else begin
          next_s = state_r;
        end
      end
      SEND_WAKE: begin
        if (timeout_s || oob.tx_oob_complete) next_s = WAIT_FOR_WAKE;
        else                                  next_s = state_r;
      end
      WAIT_FOR_WAKE: begin
        if (oob.comm_wake_detect) next_s = WAIT_FOR_NO_WAKE;
        else if (timeout_s)       fail_s = 1'b1;
        else                      next_s = state_r;
      end
      WAIT_FOR_NO_WAKE: begin
        if (!oob.comm_wake_detect) next_s = WAIT_FOR_ALIGN;
        else                       next_s = state_r;
      end
      WAIT_FOR_ALIGN: begin
        if (align_det_s)    next_s = SEND_ALIGN;
        else if (timeout_s) fail_s = 1'b1;
        else                next_s = state_r;
      end
      SEND_ALIGN: begin
        if (!align_det_s && release_inc_s == 8'(ALIGN_RELEASE))
          next_s = (REQUIRE_SYNC != 0) ? DETECT_SYNC : READY;
        else
          next_s = state_r;
      end
      DETECT_SYNC: begin
        if (sync_det_s)     next_s = READY;
        else if (timeout_s) fail_s = 1'b1;
        else                next_s = state_r;
      end
      READY: begin
        if (oob.comm_init_detect) begin
          next_s = IDLE;
        end else if (oob.rx_is_elec_idle && idle_inc_s == 16'(IDLE_LOSS)) begin
          next_s = IDLE;
          lost_s = 1'b1;
        end else begin
          next_s = state_r;
        end
      end
      ERROR: begin
        if (!oob.platform_ready) next_s = IDLE;
        else                     next_s = state_r;
      end
      default: next_s = IDLE;
    endcase
    if (fail_s) begin
      if (retry_r < 4'(MAX_RETRIES)) begin
        next_s       = SEND_RESET;
        retry_inc_s  = 1'b1;
        comm_reset_s = 1'b1;
      end else begin
        next_s = ERROR;
      end
    end else begin
      retry_inc_s = 1'b0;
    end
    // Losing the platform aborts any active sequence, overriding everything else.
    if (!oob.platform_ready && state_r != IDLE && state_r != ERROR) begin
      next_s       = IDLE;
      retry_inc_s  = 1'b0;
      comm_reset_s = 1'b0;
      comm_wake_s  = 1'b0;
      lost_s       = 1'b0;
    end else begin
      lost_s = lost_s;
    end
  end

  // Transmit data path values for the state about to be entered.
  always_comb begin
    dout_nxt_s      = 32'd0;
    is_k_nxt_s      = 1'b0;
    elec_idle_nxt_s = 1'b1;
    case (next_s)
      WAIT_FOR_ALIGN: begin
        dout_nxt_s      = DIALTONE;
        is_k_nxt_s      = 1'b0;
        elec_idle_nxt_s = 1'b0;
      end
      SEND_ALIGN, DETECT_SYNC: begin
        dout_nxt_s      = PRIM_ALIGN;
        is_k_nxt_s      = 1'b1;
        elec_idle_nxt_s = 1'b0;
      end
      READY: begin
        dout_nxt_s      = dout_r;
        is_k_nxt_s      = is_k_r;
        elec_idle_nxt_s = 1'b0;
      end
      default: begin
        dout_nxt_s      = 32'd0;
        is_k_nxt_s      = 1'b0;
        elec_idle_nxt_s = 1'b1;
      end
    endcase
  end

  assign oob.platform_error   = platform_error_r;
  assign oob.linkup           = linkup_r;
  assign oob.link_lost        = link_lost_r;
  assign oob.tx_comm_reset    = comm_reset_r;
  assign oob.tx_comm_wake     = comm_wake_r;
  assign oob.tx_dout          = dout_r;
  assign oob.tx_is_k          = is_k_r;
  assign oob.tx_set_elec_idle = elec_idle_r;
  assign oob.retry_count      = retry_r;
  assign oob.lax_state        = state_r;

endmodule
